// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared types, constants and LFSR helpers for the sparse job sequencer
//
// Contents:
//   state_t             sequencer FSM states
//   LFSR_MASK           Galois feedback mask for x^16+x^14+x^13+x^11+1
//   LFSR_DEFAULT        LFSR reset value and substitute for a zero seed
//   lfsr_next()         one right-shift step of the Galois LFSR
//   lfsr_slot_is_real() slot decision taken from the current LFSR state
package seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        PICK,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        FINISH
    } state_t;

    localparam logic [15:0] LFSR_MASK    = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LFSR_MASK : 16'h0000);
    endfunction

    // A set LSB selects a real job when both kinds are still pending.
    function automatic logic lfsr_slot_is_real(input logic [15:0] s);
        return s[0];
    endfunction

endpackage

// File: rtl/sparse_job_sequencer_if.sv
// rtl/sparse_job_sequencer_if.sv - accumulator clear port and controller job handshake
//
// Signals:
//   acc_sel_o    sequencer owns the accumulator write port
//   acc_addr_o   accumulator clear address
//   acc_we_o     accumulator clear write enable
//   acc_wdata_o  accumulator clear data (always zero)
//   ctrl_start   one-cycle job start pulse to the controller
//   ctrl_addr_o  sparse entry address for the job
//   ctrl_dummy_o job is a dummy (trace only)
//   ctrl_busy    controller busy, driven by the controller
// Modports: master = sequencer, slave = accumulator/controller side.
interface sparse_job_sequencer_if #(
    parameter int WORD_WIDTH = 32
);
    logic                  acc_sel_o;
    logic [9:0]            acc_addr_o;
    logic                  acc_we_o;
    logic [WORD_WIDTH-1:0] acc_wdata_o;
    logic                  ctrl_start;
    logic [9:0]            ctrl_addr_o;
    logic                  ctrl_dummy_o;
    logic                  ctrl_busy;

    modport master (
        output acc_sel_o, acc_addr_o, acc_we_o, acc_wdata_o,
        output ctrl_start, ctrl_addr_o, ctrl_dummy_o,
        input  ctrl_busy
    );

    modport slave (
        input  acc_sel_o, acc_addr_o, acc_we_o, acc_wdata_o,
        input  ctrl_start, ctrl_addr_o, ctrl_dummy_o,
        output ctrl_busy
    );
endinterface

// File: rtl/sparse_job_sequencer_lfsr.sv
// rtl/sparse_job_sequencer_lfsr.sv - 16-bit right-shifting Galois LFSR with seed load
//
// Ports:
//   clk    in   clock, rising edge
//   rst    in   asynchronous active-high reset, state -> LFSR_DEFAULT
//   load   in   load seed (zero seed replaced by LFSR_DEFAULT); wins over step
//   seed   in   16-bit seed
//   step   in   advance one position
//   state  out  current LFSR value
module galois_lfsr16
    import seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        step,
    output logic [15:0] state
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LFSR_DEFAULT;
        end else if (load) begin
            // An all-zero state would lock the LFSR, so zero seeds fall back to the default.
            state <= (seed == 16'h0000) ? LFSR_DEFAULT : seed;
        end else if (step) begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/sparse_job_sequencer.sv
// rtl/sparse_job_sequencer.sv - clears accumulator memory then dispatches real and dummy controller jobs
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset
//   start    in   run request pulse, honoured only in IDLE
//   seed_i   in   LFSR seed, sampled on accepted start
//   busy     out  run in progress
//   done     out  one-cycle pulse at end of run
//   error    out  sticky controller start timeout, cleared on next accepted start
//   bus      master modport: accumulator clear port and controller job handshake
module sparse_job_sequencer
    import seq_pkg::*;
#(
    parameter int WORD_WIDTH = 32,
    parameter int MEM_SIZE   = 553,
    parameter int REAL_JOBS  = 50,
    parameter int DUMMY_JOBS = 16,
    parameter int DUMMY_BASE = 64,
    parameter int START_TO   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [15:0]                   seed_i,
    output logic                          busy,
    output logic                          done,
    output logic                          error,
    sparse_job_sequencer_if.master        bus
);

    localparam int TW = $clog2(START_TO + 1);

    state_t        state;
    logic [9:0]    acc_addr_q;
    logic          acc_sel_q;
    logic          acc_we_q;
    logic          ctrl_start_q;
    logic [9:0]    ctrl_addr_q;
    logic          ctrl_dummy_q;
    logic [6:0]    rem_real;
    logic [6:0]    rem_dummy;
    logic [6:0]    real_idx;
    logic [6:0]    dummy_idx;
    logic [TW-1:0] timer;
    logic          ctrl_busy_q;
    logic [15:0]   lfsr_q;
    logic          lfsr_load;
    logic          lfsr_step;
    logic          pick_real;

    assign lfsr_load = (state == IDLE) && start;
    assign lfsr_step = (state == PICK);

    // Forcing order: no dummies left -> real; no reals left -> dummy; else the LFSR decides.
    always_comb begin
        pick_real = 1'b0;
        if (rem_dummy == 7'd0) begin
            pick_real = 1'b1;
        end else if (rem_real == 7'd0) begin
            pick_real = 1'b0;
        end else begin
            pick_real = lfsr_slot_is_real(lfsr_q);
        end
    end

    galois_lfsr16 u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (lfsr_load),
        .seed  (seed_i),
        .step  (lfsr_step),
        .state (lfsr_q)
    );

    assign bus.acc_sel_o    = acc_sel_q;
    assign bus.acc_addr_o   = acc_addr_q;
    assign bus.acc_we_o     = acc_we_q;
    assign bus.acc_wdata_o  = {WORD_WIDTH{1'b0}};
    assign bus.ctrl_start   = ctrl_start_q;
    assign bus.ctrl_addr_o  = ctrl_addr_q;
    assign bus.ctrl_dummy_o = ctrl_dummy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            acc_addr_q   <= 10'd0;
            acc_sel_q    <= 1'b0;
            acc_we_q     <= 1'b0;
            ctrl_start_q <= 1'b0;
            ctrl_addr_q  <= 10'd0;
            ctrl_dummy_q <= 1'b0;
            rem_real     <= 7'd0;
            rem_dummy    <= 7'd0;
            real_idx     <= 7'd0;
            dummy_idx    <= 7'd0;
            timer        <= '0;
            ctrl_busy_q  <= 1'b0;
        end else begin
            ctrl_busy_q  <= bus.ctrl_busy;
            done         <= 1'b0;
            ctrl_start_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        rem_real   <= 7'(REAL_JOBS);
                        rem_dummy  <= 7'(DUMMY_JOBS);
                        real_idx   <= 7'd0;
                        dummy_idx  <= 7'd0;
                        busy       <= 1'b1;
                        error      <= 1'b0;
                        acc_sel_q  <= 1'b1;
                        acc_we_q   <= 1'b1;
                        acc_addr_q <= 10'd0;
                        state      <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (acc_addr_q == 10'(MEM_SIZE - 1)) begin
                        acc_sel_q  <= 1'b0;
                        acc_we_q   <= 1'b0;
                        acc_addr_q <= 10'd0;
                        state      <= PICK;
                    end else begin
                        acc_addr_q <= acc_addr_q + 10'd1;
                    end
                end
                PICK: begin
                    if (pick_real) begin
                        ctrl_addr_q  <= {3'b000, real_idx};
                        ctrl_dummy_q <= 1'b0;
                        real_idx     <= real_idx + 7'd1;
                        rem_real     <= rem_real - 7'd1;
                    end else begin
                        ctrl_addr_q  <= 10'(DUMMY_BASE) + {3'b000, dummy_idx};
                        ctrl_dummy_q <= 1'b1;
                        dummy_idx    <= dummy_idx + 7'd1;
                        rem_dummy    <= rem_dummy - 7'd1;
                    end
                    // Registered so the pulse lines up with the ISSUE cycle.
                    ctrl_start_q <= 1'b1;
                    state        <= ISSUE;
                end
                ISSUE: begin
                    timer <= '0;
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (bus.ctrl_busy) begin
                        state <= WAIT_DONE;
                    end else if (timer == TW'(START_TO - 1)) begin
                        error <= 1'b1;
                        state <= FINISH;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    // Completion is the busy falling edge; the controller's done flag is sticky.
                    if (ctrl_busy_q && !bus.ctrl_busy) begin
                        if (rem_real == 7'd0 && rem_dummy == 7'd0) begin
                            state <= FINISH;
                        end else begin
                            state <= PICK;
                        end
                    end
                end
                FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
